// File: rtl/instr_register_exec_if.sv
// Instruction-register write/read bus between the requester and the responder.
interface instr_register_exec_if #(
    parameter int OP_W  = 32,
    parameter int RES_W = 64,
    parameter int AW    = 5
);
    logic                        load_en;
    logic [AW-1:0]               write_pointer;
    logic [2:0]                  opcode;
    logic [OP_W-1:0]             operand_a;
    logic [OP_W-1:0]             operand_b;
    logic                        wr_ready;
    logic                        wr_done;
    logic [AW-1:0]               read_pointer;
    logic [3+2*OP_W+RES_W-1:0]   instruction_word;

    modport master (
        output load_en, write_pointer, opcode, operand_a, operand_b, read_pointer,
        input  wr_ready, wr_done, instruction_word
    );

    modport slave (
        input  load_en, write_pointer, opcode, operand_a, operand_b, read_pointer,
        output wr_ready, wr_done, instruction_word
    );
endinterface

// File: rtl/instr_register_exec.sv
// Instruction register with per-entry result computation. Single-cycle
// opcodes commit at the accept edge; DIV/MOD run an iterative restoring
// divider and commit OP_W+1 cycles after acceptance.
module instr_register_exec #(
    parameter int OP_W  = 32,
    parameter int RES_W = 64,
    parameter int DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    instr_register_exec_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 3 + 2*OP_W + RES_W;
    localparam int CW = $clog2(OP_W);

    typedef enum logic [2:0] {
        OP_ZERO  = 3'd0,
        OP_PASSA = 3'd1,
        OP_PASSB = 3'd2,
        OP_ADD   = 3'd3,
        OP_SUB   = 3'd4,
        OP_MULT  = 3'd5,
        OP_DIV   = 3'd6,
        OP_MOD   = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        COMMIT
    } state_t;

    state_t state, state_nxt;

    logic [EW-1:0] mem [DEPTH];

    // Divider context latched at acceptance
    logic [2:0]      div_opc;
    logic [AW-1:0]   div_addr;
    logic [OP_W-1:0] div_a;
    logic [OP_W-1:0] div_b;
    logic [OP_W-1:0] div_den;
    logic [OP_W-1:0] div_quo;
    logic [OP_W-1:0] div_rem;
    logic [CW-1:0]   div_cnt;

    logic             accept;
    logic             is_div;
    logic             b_zero;
    logic             div_start;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [EW-1:0]    wr_entry;
    logic [RES_W-1:0] a_ext;
    logic [RES_W-1:0] b_ext;
    logic [RES_W-1:0] alu_res;
    logic [OP_W-1:0]  a_mag;
    logic [OP_W-1:0]  b_mag;
    logic [OP_W:0]    rem_sh;
    logic [OP_W:0]    rem_diff;
    logic [RES_W-1:0] q_mag;
    logic [RES_W-1:0] r_mag;
    logic [RES_W-1:0] q_res;
    logic [RES_W-1:0] r_res;

    assign accept = bus.load_en && (state == IDLE);
    assign is_div = (bus.opcode == OP_DIV) || (bus.opcode == OP_MOD);
    assign b_zero = (bus.operand_b == '0);
    assign a_ext  = {{(RES_W-OP_W){bus.operand_a[OP_W-1]}}, bus.operand_a};
    assign b_ext  = {{(RES_W-OP_W){bus.operand_b[OP_W-1]}}, bus.operand_b};
    assign a_mag  = bus.operand_a[OP_W-1] ? (~bus.operand_a + 1'b1) : bus.operand_a;
    assign b_mag  = bus.operand_b[OP_W-1] ? (~bus.operand_b + 1'b1) : bus.operand_b;

    // One restoring step: shift the next dividend bit into the partial remainder
    assign rem_sh   = {div_rem, div_quo[OP_W-1]};
    assign rem_diff = rem_sh - {1'b0, div_den};

    // Sign correction: quotient negative on differing signs, remainder follows dividend
    assign q_mag = {{(RES_W-OP_W){1'b0}}, div_quo};
    assign r_mag = {{(RES_W-OP_W){1'b0}}, div_rem};
    assign q_res = (div_a[OP_W-1] ^ div_b[OP_W-1]) ? (~q_mag + 1'b1) : q_mag;
    assign r_res = div_a[OP_W-1] ? (~r_mag + 1'b1) : r_mag;

    // Single-cycle result for the incoming opcode (DIV/MOD here only for b == 0)
    always_comb begin
        alu_res = '0;
        case (op_t'(bus.opcode))
            OP_ZERO:  alu_res = '0;
            OP_PASSA: alu_res = a_ext;
            OP_PASSB: alu_res = b_ext;
            OP_ADD:   alu_res = a_ext + b_ext;
            OP_SUB:   alu_res = a_ext - b_ext;
            OP_MULT:  alu_res = $signed(a_ext) * $signed(b_ext);
            default:  alu_res = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, handshake and commit selection
    always_comb begin
        state_nxt    = state;
        bus.wr_ready = 1'b0;
        div_start    = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = bus.write_pointer;
        wr_entry     = {bus.opcode, bus.operand_a, bus.operand_b, alu_res};
        case (state)
            IDLE: begin
                bus.wr_ready = 1'b1;
                if (accept) begin
                    if (is_div && !b_zero) begin
                        div_start = 1'b1;
                        state_nxt = DIVIDE;
                    end else begin
                        wr_en = 1'b1;
                    end
                end
            end
            DIVIDE: begin
                if (div_cnt == CW'(OP_W-1)) begin
                    state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                wr_en     = 1'b1;
                wr_addr   = div_addr;
                wr_entry  = {div_opc, div_a, div_b, (div_opc == OP_MOD) ? r_res : q_res};
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Divider datapath: latch on start, one quotient bit per DIVIDE cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            div_opc  <= '0;
            div_addr <= '0;
            div_a    <= '0;
            div_b    <= '0;
            div_den  <= '0;
            div_quo  <= '0;
            div_rem  <= '0;
            div_cnt  <= '0;
        end else if (div_start) begin
            div_opc  <= bus.opcode;
            div_addr <= bus.write_pointer;
            div_a    <= bus.operand_a;
            div_b    <= bus.operand_b;
            div_den  <= b_mag;
            div_quo  <= a_mag;
            div_rem  <= '0;
            div_cnt  <= '0;
        end else if (state == DIVIDE) begin
            if (!rem_diff[OP_W]) begin
                div_rem <= rem_diff[OP_W-1:0];
                div_quo <= {div_quo[OP_W-2:0], 1'b1};
            end else begin
                div_rem <= rem_sh[OP_W-1:0];
                div_quo <= {div_quo[OP_W-2:0], 1'b0};
            end
            div_cnt <= div_cnt + CW'(1);
        end
    end

    // Entry storage; reset clears every entry
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_entry;
        end
    end

    // Registered read (old data on same-edge collision) and commit pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.instruction_word <= '0;
            bus.wr_done          <= 1'b0;
        end else begin
            bus.instruction_word <= mem[bus.read_pointer];
            bus.wr_done          <= wr_en;
        end
    end

endmodule
